// File: rtl/mem_byte_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_sequencer_pkg
// Description : Shared types and defaults for the byte-serial data-memory
//               initiator. Holds the state encoding, the default doubleword
//               and memory sizes, and the byte-index width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_byte_sequencer_pkg;

   // Sequencer states: one request cycle in IDLE, one byte per cycle in
   // READ/WRITE, then a single DONE cycle that releases the pipeline.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int DEF_DATA_BYTES = 8;
   localparam int DEF_MEM_BYTES  = 1024;

   // Width of a byte index; kept at least 1 so a single-byte build still
   // has a legal counter vector.
   function automatic int idx_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

   localparam int BYTE_IDX_W = idx_width(DEF_DATA_BYTES);

endpackage : mem_byte_sequencer_pkg
`default_nettype wire

// File: rtl/mem_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_sequencer
// Description : Turns one doubleword LDUR/STUR request from the MEM stage into
//               DATA_BYTES sequential byte accesses to a byte-wide data
//               memory (combinational read, write on strobe), stalling the
//               pipeline until the whole doubleword has been moved.
// Ports       :
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   MemRead    in   pipeline load request (held until Stall falls)
//   MemWrite   in   pipeline store request (held until Stall falls)
//   Address    in   64-bit byte address of the doubleword
//   DataWrite  in   store data
//   DataRead   out  assembled little-endian load data
//   Stall      out  freezes the front of the pipeline while high
//   AddrFault  out  one-cycle pulse: request rejected as out of range
//   MemAddr    out  byte address to the data memory
//   MemWData   out  byte to write
//   MemRd      out  byte read strobe
//   MemWr      out  byte write strobe
//   MemRData   in   byte returned by memory in the same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_sequencer
   import mem_byte_sequencer_pkg::*;
#(
   parameter int DATA_BYTES = DEF_DATA_BYTES,
   parameter int MEM_BYTES  = DEF_MEM_BYTES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    MemRead,
   input  logic                    MemWrite,
   input  logic [63:0]             Address,
   input  logic [8*DATA_BYTES-1:0] DataWrite,
   output logic [8*DATA_BYTES-1:0] DataRead,
   output logic                    Stall,
   output logic                    AddrFault,
   output logic [63:0]             MemAddr,
   output logic [7:0]              MemWData,
   output logic                    MemRd,
   output logic                    MemWr,
   input  logic [7:0]              MemRData
);

   localparam int                DW         = 8 * DATA_BYTES;
   localparam int                IDX_W      = idx_width(DATA_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DATA_BYTES - 1);
   // Highest legal base address: the last byte of the doubleword must still
   // fall inside the memory.
   localparam logic [63:0]       ADDR_LIMIT = 64'(MEM_BYTES - DATA_BYTES);

   state_t            state, state_next;
   logic [IDX_W-1:0]  idx;
   logic [63:0]       base;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     shadow;
   logic [DW-1:0]     assembled;

   logic              accept;
   logic              fault;
   logic              last_byte;

   assign last_byte = (idx == LAST_IDX);

   // Shadow register with the byte arriving this cycle merged in. At the last
   // byte this is the complete doubleword, so DataRead can be loaded in the
   // same cycle as the final read strobe.
   always_comb begin
      assembled                    = shadow;
      assembled[int'(idx)*8 +: 8]  = MemRData;
   end

   // Next-state and memory-side outputs.
   always_comb begin
      state_next = state;
      Stall      = 1'b0;
      MemRd      = 1'b0;
      MemWr      = 1'b0;
      MemAddr    = '0;
      MemWData   = '0;
      accept     = 1'b0;
      fault      = 1'b0;

      case (state)
         S_IDLE: begin
            // The request cycle itself must already hold the pipeline.
            Stall = MemRead | MemWrite;
            if (MemRead || MemWrite) begin
               if (Address > ADDR_LIMIT) begin
                  fault      = 1'b1;
                  state_next = S_DONE;
               end else begin
                  accept     = 1'b1;
                  state_next = MemWrite ? S_WRITE : S_READ;
               end
            end
         end
         S_READ: begin
            Stall   = 1'b1;
            MemRd   = 1'b1;
            MemAddr = base + 64'(idx);
            if (last_byte) state_next = S_DONE;
         end
         S_WRITE: begin
            Stall    = 1'b1;
            MemWr    = 1'b1;
            MemAddr  = base + 64'(idx);
            MemWData = wdata_q[int'(idx)*8 +: 8];
            if (last_byte) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // While reset is asserted nothing may reach memory or the pipeline;
      // in particular a strobe in the reset cycle must not commit a byte.
      if (reset) begin
         Stall    = 1'b0;
         MemRd    = 1'b0;
         MemWr    = 1'b0;
         MemAddr  = '0;
         MemWData = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         base      <= '0;
         wdata_q   <= '0;
         shadow    <= '0;
         DataRead  <= '0;
         AddrFault <= 1'b0;
      end else begin
         state     <= state_next;
         AddrFault <= fault;

         if (accept) begin
            base    <= Address;
            wdata_q <= DataWrite;
            idx     <= '0;
         end

         if (state == S_READ || state == S_WRITE) begin
            idx <= last_byte ? '0 : idx + 1'b1;
         end

         if (state == S_READ) begin
            shadow <= assembled;
            if (last_byte) DataRead <= assembled;
         end
      end
   end

endmodule : mem_byte_sequencer
`default_nettype wire

// File: tb/tb_mem_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_sequencer
// Description : Directed self-checking bench for mem_byte_sequencer with a
//               1 KiB byte-wide memory model (combinational read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] Address;
   logic [63:0] DataWrite;
   logic [63:0] DataRead;
   logic        Stall;
   logic        AddrFault;
   logic [63:0] MemAddr;
   logic [7:0]  MemWData;
   logic        MemRd;
   logic        MemWr;
   logic [7:0]  MemRData;

   int checks = 0;
   int errors = 0;

   // Memory model; the bench preloads through the same write port.
   logic [7:0] mem [0:1023];
   logic       pre_we = 1'b0;
   logic [9:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   assign MemRData = (MemAddr < 64'd1024) ? mem[MemAddr[9:0]] : 8'h00;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (MemWr && MemAddr < 64'd1024) mem[MemAddr[9:0]] <= MemWData;
   end

   always #5 clk = ~clk;

   mem_byte_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .DataWrite (DataWrite),
      .DataRead  (DataRead),
      .Stall     (Stall),
      .AddrFault (AddrFault),
      .MemAddr   (MemAddr),
      .MemWData  (MemWData),
      .MemRd     (MemRd),
      .MemWr     (MemWr),
      .MemRData  (MemRData)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      MemRead = 1'b1;   // a request during reset must not raise Stall
      tick();
      tick();
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
      checks++; if ({MemRd, MemWr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {MemRd, MemWr}); end
      checks++; if (MemAddr !== 64'd0 || MemWData !== 8'd0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", MemAddr, MemWData); end
      checks++; if (AddrFault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", AddrFault); end
      checks++; if (DataRead !== 64'd0) begin errors++; $display("FAIL reset_dataread: got %h want 0", DataRead); end
      reset   = 1'b0;
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_load();
      for (int k = 0; k < 8; k++) preload(10'h10 + 10'(k), 8'(k + 1));
      MemRead = 1'b1;
      Address = 64'h10;
      #1;
      checks++; if (Stall !== 1'b1 || MemRd !== 1'b0) begin errors++; $display("FAIL load_T: stall/rd got %b%b want 10", Stall, MemRd); end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({MemRd, MemWr, Stall} !== 3'b101 || MemAddr !== 64'h10 + 64'(k)) begin
            errors++; $display("FAIL load_strobe%0d: rd/wr/stall %b addr %h want 101 addr %h", k, {MemRd, MemWr, Stall}, MemAddr, 64'h10 + 64'(k));
         end
      end
      tick();
      checks++; if (Stall !== 1'b0 || MemRd !== 1'b0) begin errors++; $display("FAIL load_T9: stall/rd got %b%b want 00", Stall, MemRd); end
      checks++; if (DataRead !== 64'h0807060504030201) begin errors++; $display("FAIL load_data: got %h want 0807060504030201", DataRead); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_store();
      logic [7:0] exp_b [8];
      exp_b = '{8'h11, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      MemWrite  = 1'b1;
      Address   = 64'h20;
      DataWrite = 64'hAABBCCDDEEFF0011;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL store_T: stall got %b want 1", Stall); end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({MemRd, MemWr, Stall} !== 3'b011 || MemAddr !== 64'h20 + 64'(k) || MemWData !== exp_b[k]) begin
            errors++; $display("FAIL store_strobe%0d: rd/wr/stall %b addr %h data %h want 011 addr %h data %h",
                               k, {MemRd, MemWr, Stall}, MemAddr, MemWData, 64'h20 + 64'(k), exp_b[k]);
         end
      end
      tick();
      checks++; if (Stall !== 1'b0 || MemWr !== 1'b0) begin errors++; $display("FAIL store_T9: stall/wr got %b%b want 00", Stall, MemWr); end
      MemWrite = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         checks++; if (mem[10'h20 + 10'(k)] !== exp_b[k]) begin errors++; $display("FAIL store_mem%0d: got %h want %h", k, mem[10'h20 + 10'(k)], exp_b[k]); end
      end
      // Reload the stored doubleword.
      MemRead = 1'b1;
      Address = 64'h20;
      repeat (9) tick();
      checks++; if (DataRead !== 64'hAABBCCDDEEFF0011 || Stall !== 1'b0) begin errors++; $display("FAIL store_reload: got %h stall %b want aabbccddeeff0011 stall 0", DataRead, Stall); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_both_strobes();
      int rd_seen = 0;
      int wr_seen = 0;
      MemRead   = 1'b1;
      MemWrite  = 1'b1;
      Address   = 64'h40;
      DataWrite = 64'h0123456789ABCDEF;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (MemRd) rd_seen++;
         if (MemWr) wr_seen++;
      end
      checks++; if (rd_seen != 0) begin errors++; $display("FAIL both_rd: MemRd cycles %0d want 0", rd_seen); end
      checks++; if (wr_seen != 8) begin errors++; $display("FAIL both_wr: MemWr cycles %0d want 8", wr_seen); end
      checks++; if (mem[10'h40] !== 8'hEF || mem[10'h47] !== 8'h01) begin errors++; $display("FAIL both_mem: got %h..%h want ef..01", mem[10'h40], mem[10'h47]); end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      tick();
   endtask

   task automatic test_bounds();
      MemRead = 1'b1;
      Address = 64'd1017;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL bounds_T: stall got %b want 1", Stall); end
      tick();
      checks++; if (AddrFault !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL bounds_T1: fault/stall got %b%b want 10", AddrFault, Stall); end
      checks++; if ({MemRd, MemWr} !== 2'b00) begin errors++; $display("FAIL bounds_strobes: got %b want 00", {MemRd, MemWr}); end
      checks++; if (DataRead !== 64'hAABBCCDDEEFF0011) begin errors++; $display("FAIL bounds_data: got %h want aabbccddeeff0011", DataRead); end
      MemRead = 1'b0;
      tick();
      checks++; if (AddrFault !== 1'b0) begin errors++; $display("FAIL bounds_pulse: fault got %b want 0", AddrFault); end
      tick();
      for (int k = 0; k < 8; k++) preload(10'd1016 + 10'(k), 8'hC0 + 8'(k));
      MemRead = 1'b1;
      Address = 64'd1016;
      tick();
      checks++; if (AddrFault !== 1'b0 || MemRd !== 1'b1 || MemAddr !== 64'd1016) begin errors++; $display("FAIL bounds_1016_first: fault %b rd %b addr %h want 0 1 3f8", AddrFault, MemRd, MemAddr); end
      repeat (7) tick();
      checks++; if (MemAddr !== 64'd1023 || MemRd !== 1'b1) begin errors++; $display("FAIL bounds_1016_last: addr %h rd %b want 3ff 1", MemAddr, MemRd); end
      tick();
      checks++; if (DataRead !== 64'hC7C6C5C4C3C2C1C0) begin errors++; $display("FAIL bounds_1016_data: got %h want c7c6c5c4c3c2c1c0", DataRead); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 8; k++) preload(10'h60 + 10'(k), 8'h5A);
      MemWrite  = 1'b1;
      Address   = 64'h60;
      DataWrite = 64'h8877665544332211;
      repeat (4) tick();        // now in T+4, byte 3 pending
      reset = 1'b1;
      #1;
      checks++; if (MemWr !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL rstmid_T4: wr/stall got %b%b want 00", MemWr, Stall); end
      tick();
      reset    = 1'b0;
      MemWrite = 1'b0;
      #1;
      checks++; if ({MemRd, MemWr, Stall} !== 3'b000) begin errors++; $display("FAIL rstmid_T5: rd/wr/stall got %b want 000", {MemRd, MemWr, Stall}); end
      checks++; if (DataRead !== 64'd0) begin errors++; $display("FAIL rstmid_data: got %h want 0", DataRead); end
      checks++; if ({mem[10'h60], mem[10'h61], mem[10'h62]} !== 24'h112233) begin errors++; $display("FAIL rstmid_written: got %h%h%h want 112233", mem[10'h60], mem[10'h61], mem[10'h62]); end
      checks++; if ({mem[10'h63], mem[10'h64], mem[10'h65], mem[10'h66], mem[10'h67]} !== 40'h5A5A5A5A5A) begin
         errors++; $display("FAIL rstmid_untouched: got %h%h%h%h%h want 5a5a5a5a5a", mem[10'h63], mem[10'h64], mem[10'h65], mem[10'h66], mem[10'h67]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      MemRead = 1'b1;
      Address = 64'h10;
      repeat (9) tick();        // T+9: DONE
      checks++; if (DataRead !== 64'h0807060504030201 || Stall !== 1'b0) begin errors++; $display("FAIL b2b_load: got %h stall %b want 0807060504030201 0", DataRead, Stall); end
      // Next instruction's store appears while DONE; it must not start yet.
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Address   = 64'h80;
      DataWrite = 64'h1122334455667788;
      #1;
      checks++; if ({MemRd, MemWr, Stall} !== 3'b000) begin errors++; $display("FAIL b2b_T9: rd/wr/stall got %b want 000", {MemRd, MemWr, Stall}); end
      tick();                   // T+10: IDLE, request seen
      checks++; if ({MemRd, MemWr, Stall} !== 3'b001) begin errors++; $display("FAIL b2b_T10: rd/wr/stall got %b want 001", {MemRd, MemWr, Stall}); end
      tick();                   // T+11: first store strobe
      checks++; if (MemWr !== 1'b1 || MemAddr !== 64'h80 || MemWData !== 8'h88) begin errors++; $display("FAIL b2b_T11: wr %b addr %h data %h want 1 80 88", MemWr, MemAddr, MemWData); end
      repeat (7) tick();
      checks++; if (MemWr !== 1'b1 || MemAddr !== 64'h87 || MemWData !== 8'h11) begin errors++; $display("FAIL b2b_T18: wr %b addr %h data %h want 1 87 11", MemWr, MemAddr, MemWData); end
      tick();
      checks++; if (Stall !== 1'b0 || MemWr !== 1'b0) begin errors++; $display("FAIL b2b_T19: stall/wr got %b%b want 00", Stall, MemWr); end
      MemWrite = 1'b0;
      tick();
      checks++; if (mem[10'h80] !== 8'h88 || mem[10'h84] !== 8'h44) begin errors++; $display("FAIL b2b_mem: got %h %h want 88 44", mem[10'h80], mem[10'h84]); end
   endtask

   initial begin
      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      DataWrite = '0;
      test_reset();
      test_load();
      test_store();
      test_both_strobes();
      test_bounds();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_byte_sequencer
`default_nettype wire

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Pipeline-side initiator for the byte-wide data memory: turns one 64-bit LDUR/STUR request from the MEM stage into eight sequential byte accesses.
- Sits between the EX/MEM pipeline register and the byte-organised data memory (8-bit words, combinational read, write on strobe).
- Holds the pipeline with Stall until the full doubleword has been transferred.

Parameters:
- DATA_BYTES, 8, bytes per pipeline access (little-endian assembly).
- MEM_BYTES, 1024, size of the data memory in bytes; used for the bounds check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  pipeline load request, held until Stall falls.
- MemWrite  input  1  pipeline store request, held until Stall falls.
- Address  input  64  byte address of the doubleword.
- DataWrite  input  64  store data.
- DataRead  output  64  assembled load data.
- Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- AddrFault  output  1  one-cycle pulse: request rejected as out of range.
- MemAddr  output  64  byte address to the data memory.
- MemWData  output  8  byte to write.
- MemRd  output  1  byte read strobe.
- MemWr  output  1  byte write strobe.
- MemRData  input  8  byte returned by memory, same cycle (combinational).

Behaviour:
- Reset values: state IDLE, DataRead 0, MemAddr 0, MemWData 0, MemRd 0, MemWr 0, AddrFault 0, byte index 0.
- Stall is 0 in reset.
- States:
  - IDLE: waits for a request.
  - READ, WRITE: one byte per cycle, index i = 0..7.
  - DONE: one cycle; Stall is 0 so the pipeline advances.
- IDLE behaviour:
  - Stall = MemRead | MemWrite (combinational), so the request cycle is already stalled.
  - On a request, latch Address and DataWrite.
  - Go to WRITE if MemWrite is high (write wins when both are high). Otherwise go to READ.
- Bounds check in IDLE: if Address > MEM_BYTES - DATA_BYTES, pulse AddrFault the next cycle and go to DONE without issuing any strobe. Stall is 0 that cycle. DataRead is unchanged.
- Address arithmetic: MemAddr = latched address + i, 64-bit unsigned. Overflow cannot occur after the bounds check.
- READ:
  - MemRd = 1 and MemAddr = base + i.
  - Capture MemRData into bits [8i+7:8i] of a shadow register in the same cycle.
  - After i = 7, copy the shadow register to DataRead and go to DONE.
- WRITE:
  - MemWr = 1, MemAddr = base + i, MemWData = latched DataWrite[8i+7:8i].
  - After i = 7, go to DONE.
- Timing: request first seen in IDLE at cycle T.
  - Strobes in T+1..T+8.
  - DONE at T+9.
  - Stall is high T..T+8 and low at T+9.
  - DataRead is valid from T+9 and held until the next load completes.
- MemRd and MemWr are never high together, and both are 0 in IDLE and DONE.
- DONE always returns to IDLE. A new request arriving at T+10 starts a fresh access.
- Request inputs are ignored while in READ, WRITE or DONE; the latched copies are used.
- Reset mid-access: back to IDLE next cycle with strobes low. Bytes already written stay in memory. DataRead keeps its reset value 0.

Decomposition:
- Shared package:
  - state encoding (IDLE, READ, WRITE, DONE);
  - DATA_BYTES and MEM_BYTES defaults;
  - byte-index width constant $clog2(DATA_BYTES).
- No sub-module: the state machine, byte counter and shift/assemble datapath are implemented in one module.

Test Plan:
- Load: memory bytes 0x10..0x17 preloaded 01..08; MemRead, Address 0x10 -> MemAddr steps 0x10..0x17 with MemRd high at T+1..T+8; Stall high T..T+8; DataRead = 0x0807060504030201 at T+9.
- Store: MemWrite, Address 0x20, DataWrite 0xAABBCCDDEEFF0011 -> MemWr bytes 11,00,FF,EE,DD,CC,BB,AA to 0x20..0x27; Stall low at T+9; a reload of 0x20 returns the same value.
- Both strobes: MemRead=MemWrite=1 -> write sequence only; MemRd stays 0 throughout.
- Bounds: Address 1017 (0x3F9) -> no strobes; AddrFault pulse at T+1; Stall low at T+1. Address 1016 -> normal access.
- Reset at T+4 of a store -> IDLE at T+5; Stall 0; bytes 0..2 written, bytes 3..7 unchanged.
- Back-to-back: load then store on consecutive requests -> second access's first strobe at T+11; no overlap between the two accesses.
